// File: rtl/cook_timer.sv
// Microwave cook timer: BCD mm:ss keypad entry, per-second countdown while heat
// is high, hold while heat is low, and a single finish pulse on expiry.
module cook_timer #(
  parameter int TICKS_PER_SEC = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       heat,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       key_clear,
  output logic       finish,
  output logic       ready,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones
);

  localparam int             PW   = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0]  PMAX = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {SET = 2'd0, RUN = 2'd1, HOLD = 2'd2, DONE = 2'd3} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [15:0]   digits;
  logic [15:0]   digits_dec;
  logic          time_zero;
  logic          dec_zero;

  // One-second BCD decrement; seconds tens may hold up to 9 (0:90 is 90 s).
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = t;
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else if (st != 4'd0) begin
      st = st - 4'd1;
      so = 4'd9;
    end else begin
      st = 4'd5;
      so = 4'd9;
      if (mo != 4'd0) begin
        mo = mo - 4'd1;
      end else begin
        mo = 4'd9;
        mt = mt - 4'd1;
      end
    end
    return {mt, mo, st, so};
  endfunction

  assign digits     = {min_tens, min_ones, sec_tens, sec_ones};
  assign digits_dec = bcd_dec(digits);
  assign time_zero  = (digits == 16'h0000);
  assign dec_zero   = (digits_dec == 16'h0000);
  assign ready      = ((state == SET) || (state == HOLD)) && !time_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SET;
      presc    <= '0;
      finish   <= 1'b0;
      min_tens <= 4'd0;
      min_ones <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
    end else begin
      finish <= 1'b0;
      case (state)
        SET: begin
          if (heat) begin
            if (time_zero) begin
              state  <= DONE;
              finish <= 1'b1;
            end else begin
              state <= RUN;
              presc <= '0;
            end
          end else if (key_clear) begin
            {min_tens, min_ones, sec_tens, sec_ones} <= 16'h0000;
          end else if (key_valid && (key_digit <= 4'd9)) begin
            {min_tens, min_ones, sec_tens, sec_ones} <= {min_ones, sec_tens, sec_ones, key_digit};
          end
        end
        RUN: begin
          if (!heat) begin
            state <= HOLD;
          end else if (presc == PMAX) begin
            presc <= '0;
            {min_tens, min_ones, sec_tens, sec_ones} <= digits_dec;
            if (dec_zero) begin
              state  <= DONE;
              finish <= 1'b1;
            end
          end else begin
            presc <= presc + 1'b1;
          end
        end
        HOLD: begin
          // Prescaler is kept across the pause so a resumed second is not restarted.
          if (key_clear) begin
            {min_tens, min_ones, sec_tens, sec_ones} <= 16'h0000;
            presc <= '0;
            state <= SET;
          end else if (heat) begin
            state <= RUN;
          end
        end
        DONE: begin
          if (!heat) state <= SET;
        end
        default: state <= SET;
      endcase
    end
  end

endmodule

// File: tb/tb_cook_timer.sv
// Scoreboard bench for cook_timer: a minutes/seconds integer model predicts each
// cycle's outputs, a monitor pops and compares them one cycle at a time.
module tb_cook_timer;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       heat = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       key_clear = 1'b0;
  logic       finish, ready;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [17:0] obs;

  cook_timer #(.TICKS_PER_SEC(T)) dut (
    .clk(clk), .rst(rst), .heat(heat), .key_valid(key_valid),
    .key_digit(key_digit), .key_clear(key_clear), .finish(finish),
    .ready(ready), .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones)
  );

  assign obs = {finish, ready, min_tens, min_ones, sec_tens, sec_ones};

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [17:0] sb[$];

  typedef enum int {M_SET, M_RUN, M_HOLD, M_DONE} mode_t;
  mode_t mode = M_SET;
  int    mm = 0, ss = 0, pc = 0;
  bit    mfin = 1'b0;

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [17:0] model_out();
    bit rdy;
    rdy = ((mode == M_SET) || (mode == M_HOLD)) && ((mm != 0) || (ss != 0));
    return {mfin, rdy, 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic model_step(input bit r, input bit h, input bit kv, input int kd, input bit kc);
    int n;
    if (r) begin
      mode = M_SET; mm = 0; ss = 0; pc = 0; mfin = 1'b0;
      return;
    end
    mfin = 1'b0;
    case (mode)
      M_SET: begin
        if (h) begin
          if (mm == 0 && ss == 0) begin mode = M_DONE; mfin = 1'b1; end
          else begin mode = M_RUN; pc = 0; end
        end else if (kc) begin
          mm = 0; ss = 0;
        end else if (kv && kd <= 9) begin
          n  = ((mm * 100 + ss) * 10 + kd) % 10000;
          mm = n / 100;
          ss = n % 100;
        end
      end
      M_RUN: begin
        if (!h) mode = M_HOLD;
        else begin
          pc++;
          if (pc == T) begin
            pc = 0;
            if (ss > 0) ss--;
            else begin ss = 59; mm--; end
            if (mm == 0 && ss == 0) begin mode = M_DONE; mfin = 1'b1; end
          end
        end
      end
      M_HOLD: begin
        if (kc) begin mm = 0; ss = 0; pc = 0; mode = M_SET; end
        else if (h) mode = M_RUN;
      end
      M_DONE: if (!h) mode = M_SET;
      default: mode = M_SET;
    endcase
  endtask

  task automatic cycle(input bit r, input bit h, input bit kv, input int kd, input bit kc);
    @(negedge clk);
    rst = r; heat = h; key_valid = kv; key_digit = 4'(kd); key_clear = kc;
    model_step(r, h, kv, kd, kc);
    sb.push_back(model_out());
  endtask

  task automatic key(input int d);
    cycle(0, 0, 1, d, 0);
  endtask

  task automatic clr();
    cycle(0, 0, 0, 0, 1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(0, 1, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  // Direct check of outputs after the edge that applies the last cycle() call.
  task automatic peek(input string name, input logic [17:0] exp);
    @(posedge clk);
    #1;
    check(name, obs, exp);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) check("cycle", obs, sb.pop_front());
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit h, r, kv, kc;
    int kd;

    repeat (2) @(negedge clk);
    #1;
    check("reset_state", obs, 18'h0);
    idle(1);

    key(1); key(3); key(0);
    peek("entry_0130", {2'b01, 16'h0130});
    clr();
    peek("clear", {2'b00, 16'h0000});
    key(5); key(1); key(2); key(3); key(4);
    peek("shift_out", {2'b01, 16'h1234});
    key(11);
    peek("bad_digit", {2'b01, 16'h1234});

    clr(); key(2);
    run(5);
    peek("tick_0001", {2'b00, 16'h0001});
    run(4);
    peek("expire", {2'b10, 16'h0000});
    run(1);
    peek("no_refinish", {2'b00, 16'h0000});
    idle(1);
    key(5);
    peek("done_to_set", {2'b01, 16'h0005});

    clr(); key(1); key(0); key(0);
    run(5);
    peek("sec_borrow", {2'b00, 16'h0059});
    idle(1); clr();

    key(9); key(0);
    run(5);
    peek("ninety_89", {2'b00, 16'h0089});
    run(4);
    peek("ninety_88", {2'b00, 16'h0088});
    idle(1); clr();

    key(1); key(0); key(0); key(0);
    run(5);
    peek("min_borrow", {2'b00, 16'h0959});
    idle(1); clr();

    key(3);
    run(2);
    idle(4); cycle(0, 0, 1, 7, 0); idle(5);
    peek("pause_hold", {2'b01, 16'h0003});
    run(3);
    peek("resume_pre", {2'b00, 16'h0003});
    run(1);
    peek("resume_tick", {2'b00, 16'h0002});
    idle(1); clr();

    run(1);
    peek("zero_start", {2'b10, 16'h0000});
    run(4);
    idle(1);

    key(2); key(5);
    run(3);
    @(negedge clk);
    rst = 1'b1; heat = 1'b1;
    #1;
    check("async_rst", obs, 18'h0);
    model_step(1, 1, 0, 0, 0);
    sb.push_back(model_out());
    idle(1);

    h = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) h = !h;
      r  = ($urandom_range(0, 399) == 0);
      kv = ($urandom_range(0, 3) == 0);
      kd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2));
      kc = ($urandom_range(0, 24) == 0);
      cycle(r, h, kv, kd, kc);
    end
    idle(2);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
